// File: rtl/float_adder_arbiter.sv
// float_adder_arbiter: round-robin sharing of one FloatAdder among NUM_REQ requesters; FADD_ARB_TIMEOUT_EN enables the WAIT watchdog
module float_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [NUM_REQ-1:0]     ReqValid,
    input  logic [32*NUM_REQ-1:0]  ReqOp1,
    input  logic [32*NUM_REQ-1:0]  ReqOp2,
    output logic [NUM_REQ-1:0]     ReqReady,
    output logic [NUM_REQ-1:0]     RspValid,
    output logic [31:0]            RspResult,
    output logic [31:0]            AdderOp1,
    output logic [31:0]            AdderOp2,
    output logic                   AdderInputValid,
    input  logic [31:0]            AdderResult,
    input  logic                   AdderResultValid,
    output logic                   Busy,
    output logic                   TimeoutErr
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
    state_t state, state_next;
    logic [IW-1:0] ptr, gnt, pick;
    logic found, seen_low, capture, expire;
    logic [31:0] op1, op2, result;
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("float_adder_arbiter: parameter out of range");
    end
    assign capture = state == WAIT && AdderResultValid && seen_low;
`ifdef FADD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic to_flag;
    assign expire = state == WAIT && !capture && cnt == CW'(TIMEOUT - 1);
    assign TimeoutErr = state == RESPOND && to_flag;
    // Watchdog: counter runs only in WAIT; flag remembers whether RESPOND came from expiry
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt <= '0;
            to_flag <= 1'b0;
        end else begin
            cnt <= state == WAIT ? cnt + 1'b1 : '0;
            if (state == WAIT) to_flag <= expire;
        end
    end
`else
    assign expire = 1'b0;
    assign TimeoutErr = 1'b0;
`endif
    // Round-robin search starting at ptr, ascending modulo NUM_REQ
    always_comb begin
        found = 1'b0;
        pick = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && ReqValid[IW'((int'(ptr) + k) % NUM_REQ)]) begin
                found = 1'b1;
                pick = IW'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end
    // Next-state and strobe outputs; grants are suppressed while Reset is high
    always_comb begin
        state_next = state;
        ReqReady = '0;
        RspValid = '0;
        AdderInputValid = 1'b0;
        if (state == IDLE && found && !Reset) begin
            state_next = ISSUE;
            ReqReady = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
        end
        if (state == ISSUE) begin
            state_next = WAIT;
            AdderInputValid = 1'b1;
        end
        if (state == WAIT && (capture || expire)) state_next = RESPOND;
        if (state == RESPOND) begin
            state_next = IDLE;
            RspValid = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt;
        end
    end
    assign Busy = state != IDLE;
    assign AdderOp1 = op1;
    assign AdderOp2 = op2;
    assign RspResult = result;
    // State register
    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else state <= state_next;
    end
    // Grant latch, edge qualification of the adder result, and pointer advance
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr <= '0;
            gnt <= '0;
            op1 <= '0;
            op2 <= '0;
            result <= '0;
            seen_low <= 1'b0;
        end else begin
            if (state == IDLE && found) begin
                gnt <= pick;
                op1 <= ReqOp1[32*pick +: 32];
                op2 <= ReqOp2[32*pick +: 32];
            end
            seen_low <= state == WAIT && (seen_low || !AdderResultValid);
            if (capture) result <= AdderResult;
            else if (expire) result <= 32'h7FC00000;
            if (state == RESPOND) ptr <= (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_float_adder_arbiter.sv
// tb_float_adder_arbiter: directed scenario tests for float_adder_arbiter with the bench acting as the adder
module tb_float_adder_arbiter;
    localparam int N = 4;
    localparam logic [31:0] OPS [N] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    localparam logic [31:0] SUMS [N] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic [N-1:0] ReqValid = '0;
    logic [32*N-1:0] ReqOp1 = '0;
    logic [32*N-1:0] ReqOp2 = '0;
    logic [N-1:0] ReqReady, RspValid;
    logic [31:0] RspResult, AdderOp1, AdderOp2;
    logic AdderInputValid;
    logic [31:0] AdderResult = '0;
    logic AdderResultValid = 1'b0;
    logic Busy, TimeoutErr;
    int checks = 0;
    int errors = 0;
    int rr_cnt = 0;
    int aiv_cnt = 0;

    float_adder_arbiter #(.NUM_REQ(N), .TIMEOUT(8)) dut (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqOp1(ReqOp1), .ReqOp2(ReqOp2),
        .ReqReady(ReqReady), .RspValid(RspValid), .RspResult(RspResult),
        .AdderOp1(AdderOp1), .AdderOp2(AdderOp2), .AdderInputValid(AdderInputValid),
        .AdderResult(AdderResult), .AdderResultValid(AdderResultValid),
        .Busy(Busy), .TimeoutErr(TimeoutErr)
    );

    always #5 Clock = ~Clock;

    // Pulse counters for the single-request scenario
    always @(posedge Clock) begin
        if (|ReqReady) rr_cnt++;
        if (AdderInputValid) aiv_cnt++;
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset;
        Reset = 1'b1;
        ReqValid = '0;
        AdderResultValid = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        #1;
    endtask

    task automatic serve(input logic [31:0] res);
        tick();
        tick();
        AdderResult = res;
        AdderResultValid = 1'b1;
        tick();
        AdderResultValid = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        ReqValid = '1;
        tick();
        checks++; if (ReqReady !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", ReqReady); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
        checks++; if (RspValid !== 4'b0000) begin errors++; $display("FAIL reset_rspvalid got %b exp 0000", RspValid); end
        checks++; if (AdderInputValid !== 1'b0) begin errors++; $display("FAIL reset_aiv got %b exp 0", AdderInputValid); end
        checks++; if (AdderOp1 !== 32'h0 || AdderOp2 !== 32'h0) begin errors++; $display("FAIL reset_ops got %h %h exp 0 0", AdderOp1, AdderOp2); end
        checks++; if (RspResult !== 32'h0 || TimeoutErr !== 1'b0) begin errors++; $display("FAIL reset_result got %h %b exp 0 0", RspResult, TimeoutErr); end
        ReqValid = '0;
        tick();
        Reset = 1'b0;
        #1;
    endtask

    task automatic test_single;
        ReqOp1[31:0] = 32'h3F800000;
        ReqOp2[31:0] = 32'h40000000;
        rr_cnt = 0;
        aiv_cnt = 0;
        ReqValid = 4'b0001;
        #1;
        checks++; if (ReqReady !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", ReqReady); end
        tick();
        ReqValid = '0;
        checks++; if (AdderInputValid !== 1'b1) begin errors++; $display("FAIL single_aiv got %b exp 1", AdderInputValid); end
        checks++; if (AdderOp1 !== 32'h3F800000 || AdderOp2 !== 32'h40000000) begin errors++; $display("FAIL single_ops got %h %h exp 3f800000 40000000", AdderOp1, AdderOp2); end
        serve(32'h40400000);
        checks++; if (RspValid !== 4'b0001) begin errors++; $display("FAIL single_rspvalid got %b exp 0001", RspValid); end
        checks++; if (RspResult !== 32'h40400000) begin errors++; $display("FAIL single_result got %h exp 40400000", RspResult); end
        checks++; if (TimeoutErr !== 1'b0) begin errors++; $display("FAIL single_toerr got %b exp 0", TimeoutErr); end
        tick();
        checks++; if (RspValid !== 4'b0000 || Busy !== 1'b0) begin errors++; $display("FAIL single_idle got rsp %b busy %b exp 0000 0", RspValid, Busy); end
        checks++; if (AdderOp1 !== 32'h3F800000) begin errors++; $display("FAIL single_hold got %h exp 3f800000", AdderOp1); end
        checks++; if (rr_cnt !== 1 || aiv_cnt !== 1) begin errors++; $display("FAIL single_pulses got %0d %0d exp 1 1", rr_cnt, aiv_cnt); end
    endtask

    task automatic test_round_robin;
        do_reset();
        for (int i = 0; i < N; i++) begin
            ReqOp1[32*i +: 32] = OPS[i];
            ReqOp2[32*i +: 32] = 32'h3F800000;
        end
        ReqValid = '1;
        for (int g = 0; g < 5; g++) begin
            int e;
            e = g % N;
            #1;
            checks++; if (ReqReady !== (4'b0001 << e)) begin errors++; $display("FAIL rr_ready%0d got %b exp %b", g, ReqReady, 4'b0001 << e); end
            tick();
            checks++; if (AdderOp1 !== OPS[e]) begin errors++; $display("FAIL rr_op%0d got %h exp %h", g, AdderOp1, OPS[e]); end
            checks++; if (ReqReady !== 4'b0000) begin errors++; $display("FAIL rr_busy_ready%0d got %b exp 0000", g, ReqReady); end
            serve(SUMS[e]);
            checks++; if (RspValid !== (4'b0001 << e)) begin errors++; $display("FAIL rr_rsp%0d got %b exp %b", g, RspValid, 4'b0001 << e); end
            checks++; if (RspResult !== SUMS[e]) begin errors++; $display("FAIL rr_result%0d got %h exp %h", g, RspResult, SUMS[e]); end
            tick();
        end
        ReqValid = '0;
        tick();
    endtask

    task automatic test_stale;
        do_reset();
        ReqOp1[95:64] = 32'h40A00000;
        ReqOp2[95:64] = 32'h40A00000;
        ReqValid = 4'b0100;
        #1;
        checks++; if (ReqReady !== 4'b0100) begin errors++; $display("FAIL stale_ready got %b exp 0100", ReqReady); end
        tick();
        ReqValid = '0;
        AdderResult = 32'hDEADBEEF;
        AdderResultValid = 1'b1;
        tick();
        tick();
        checks++; if (RspValid !== 4'b0000 || Busy !== 1'b1) begin errors++; $display("FAIL stale_ignored got rsp %b busy %b exp 0000 1", RspValid, Busy); end
        AdderResultValid = 1'b0;
        tick();
        tick();
        AdderResult = 32'h41200000;
        AdderResultValid = 1'b1;
        tick();
        AdderResultValid = 1'b0;
        checks++; if (RspValid !== 4'b0100) begin errors++; $display("FAIL stale_rsp got %b exp 0100", RspValid); end
        checks++; if (RspResult !== 32'h41200000) begin errors++; $display("FAIL stale_result got %h exp 41200000", RspResult); end
        tick();
    endtask

    task automatic test_reset_in_wait;
        ReqValid = 4'b0010;
        #1;
        checks++; if (ReqReady !== 4'b0010) begin errors++; $display("FAIL rstw_ready got %b exp 0010", ReqReady); end
        tick();
        ReqValid = '0;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rstw_busy got %b exp 0", Busy); end
        for (int i = 0; i < 5; i++) tick();
        AdderResult = 32'h12345678;
        AdderResultValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (RspValid !== 4'b0000 || Busy !== 1'b0) begin errors++; $display("FAIL rstw_late%0d got rsp %b busy %b exp 0000 0", i, RspValid, Busy); end
        end
        AdderResultValid = 1'b0;
        ReqValid = '1;
        #1;
        checks++; if (ReqReady !== 4'b0001) begin errors++; $display("FAIL rstw_next got %b exp 0001", ReqReady); end
        do_reset();
    endtask

    task automatic test_withdraw;
        ReqValid = 4'b0001;
        #1;
        checks++; if (ReqReady !== 4'b0001) begin errors++; $display("FAIL wd_ready got %b exp 0001", ReqReady); end
        tick();
        ReqValid = 4'b0100;
        #1;
        checks++; if (ReqReady !== 4'b0000) begin errors++; $display("FAIL wd_ignored got %b exp 0000", ReqReady); end
        tick();
        ReqValid = '0;
        tick();
        AdderResult = 32'h40000000;
        AdderResultValid = 1'b1;
        tick();
        AdderResultValid = 1'b0;
        checks++; if (RspValid !== 4'b0001) begin errors++; $display("FAIL wd_rsp got %b exp 0001", RspValid); end
        tick();
        checks++; if (ReqReady !== 4'b0000) begin errors++; $display("FAIL wd_dropped got %b exp 0000", ReqReady); end
        tick();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL wd_busy got %b exp 0", Busy); end
    endtask

`ifdef FADD_ARB_TIMEOUT_EN
    task automatic test_timeout;
        ReqValid = 4'b0001;
        #1;
        checks++; if (ReqReady !== 4'b0001) begin errors++; $display("FAIL to_ready got %b exp 0001", ReqReady); end
        tick();
        ReqValid = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++; if (RspValid !== 4'b0000 || TimeoutErr !== 1'b0) begin errors++; $display("FAIL to_wait%0d got rsp %b err %b exp 0000 0", k, RspValid, TimeoutErr); end
        end
        tick();
        checks++; if (RspValid !== 4'b0001 || TimeoutErr !== 1'b1) begin errors++; $display("FAIL to_rsp got rsp %b err %b exp 0001 1", RspValid, TimeoutErr); end
        checks++; if (RspResult !== 32'h7FC00000) begin errors++; $display("FAIL to_result got %h exp 7fc00000", RspResult); end
        tick();
        checks++; if (TimeoutErr !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL to_after got err %b busy %b exp 0 0", TimeoutErr, Busy); end
    endtask
`else
    task automatic test_no_timeout;
        ReqValid = 4'b0001;
        #1;
        checks++; if (ReqReady !== 4'b0001) begin errors++; $display("FAIL nto_ready got %b exp 0001", ReqReady); end
        tick();
        ReqValid = '0;
        for (int k = 0; k < 200; k++) begin
            tick();
            checks++; if (Busy !== 1'b1 || RspValid !== 4'b0000) begin errors++; $display("FAIL nto_busy%0d got busy %b rsp %b exp 1 0000", k, Busy, RspValid); end
        end
        checks++; if (TimeoutErr !== 1'b0) begin errors++; $display("FAIL nto_err got %b exp 0", TimeoutErr); end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stale();
        test_reset_in_wait();
        test_withdraw();
`ifdef FADD_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
